neuron_mac_seq: RTL and testbench

NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

---
 rtl/neuron_pkg.sv | 17 +
 rtl/neuron_sat_shift.sv | 20 ++
 rtl/neuron_mac_seq.sv | 120 ++++++++++++
 tb/tb_neuron_mac_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared widths, Q8.8 limits and FSM encoding for the sequential MAC neuron.
package neuron_pkg;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int ACC_W     = 40;
  localparam int FRAC_BITS = 8;

  localparam logic signed [DATA_W-1:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] Q_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MAC  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;
endpackage

// File: rtl/neuron_sat_shift.sv
// Converts the 40-bit Q16.16-style accumulator to Q8.8 with saturation.
module neuron_sat_shift
  import neuron_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] q_o
);
  logic signed [ACC_W-1:0] shifted;
  logic                    in_range;

  always_comb begin
    shifted  = acc_i >>> FRAC_BITS;
    // Representable only when every bit above the Q8.8 sign bit matches it.
    in_range = (shifted[ACC_W-1:DATA_W-1] == '0) || (shifted[ACC_W-1:DATA_W-1] == '1);
    q_o      = shifted[DATA_W-1:0];
    if (!in_range) begin
      q_o = shifted[ACC_W-1] ? Q_MIN : Q_MAX;
    end
  end
endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential neuron: streams N_INPUTS activations against ROM weights, then
// presents a saturated Q8.8 sum plus a step-activation flag.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int                       N_INPUTS  = 10,
  parameter int                       ADDR_BASE = 1,
  parameter logic signed [DATA_W-1:0] THRESHOLD = 16'sh0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic signed [DATA_W-1:0] rom_dout,
  input  logic signed [DATA_W-1:0] x_data,
  input  logic                     x_valid,
  output logic                     x_ready,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic signed [DATA_W-1:0] y_acc,
  output logic                     y_fire,
  output state_e                   dbg_state
);
  localparam int              IDX_W    = 9;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]         rom_addr_q, rom_addr_d;
  logic                      y_valid_q, y_valid_d;
  logic signed [DATA_W-1:0]  y_acc_q, y_acc_d;
  logic                      y_fire_q, y_fire_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [DATA_W-1:0]   sum_q88;

  assign prod    = rom_dout * x_data;
  assign acc_sum = acc_q + ACC_W'(prod);

  neuron_sat_shift u_sat (
    .acc_i (acc_sum),
    .q_o   (sum_q88)
  );

  // Handshakes: a beat transfers on a rising edge where valid and ready are
  // both high; valid holds its payload stable until that edge.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    rom_addr_d = rom_addr_q;
    y_valid_d  = y_valid_q;
    y_acc_d    = y_acc_q;
    y_fire_d   = y_fire_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d      = '0;
          idx_d      = '0;
          rom_addr_d = ADDR_W'(ADDR_BASE);
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_MAC;
      ST_MAC: begin
        if (x_valid) begin
          acc_d = acc_sum;
          if (idx_q < IDX_LAST) begin
            idx_d      = idx_q + 1'b1;
            rom_addr_d = ADDR_W'(ADDR_BASE) + ADDR_W'(idx_q) + 16'd1;
            state_d    = ST_LOAD;
          end else begin
            y_valid_d = 1'b1;
            y_acc_d   = sum_q88;
            y_fire_d  = (sum_q88 > THRESHOLD);
            state_d   = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (y_ready) begin
          y_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      rom_addr_q <= '0;
      y_valid_q  <= 1'b0;
      y_acc_q    <= '0;
      y_fire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      rom_addr_q <= rom_addr_d;
      y_valid_q  <= y_valid_d;
      y_acc_q    <= y_acc_d;
      y_fire_q   <= y_fire_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign x_ready   = (state_q == ST_MAC);
  assign rom_addr  = rom_addr_q;
  assign y_valid   = y_valid_q;
  assign y_acc     = y_acc_q;
  assign y_fire    = y_fire_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: directed cases plus randomized
// weights/activations against an arithmetic reference model.
module tb_neuron_mac_seq;
  import neuron_pkg::*;

  localparam int N = 10;

  logic        clk = 1'b0;
  logic        rst, start, x_valid, y_ready;
  logic [15:0] rom_dout, x_data, rom_addr, y_acc;
  logic        busy, x_ready, y_valid, y_fire;
  state_e      dbg_state;

  logic [15:0] rom_mem [0:255];
  logic [15:0] cur_x [N];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  neuron_mac_seq #(.N_INPUTS(N), .ADDR_BASE(1), .THRESHOLD(16'sh0000)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .rom_addr(rom_addr),
    .rom_dout(rom_dout), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_valid(y_valid), .y_ready(y_ready), .y_acc(y_acc), .y_fire(y_fire),
    .dbg_state(dbg_state)
  );

  // Clock and one-cycle-latency weight ROM
  always #5 clk = ~clk;
  always @(posedge clk) rom_dout <= (rom_addr < 16'd256) ? rom_mem[rom_addr[7:0]] : 16'h0000;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: exact integer dot product, floor-shift by 8, clamp to Q8.8.
  task automatic model_push();
    longint s = 0;
    longint q;
    logic [15:0] qa;
    for (int k = 0; k < N; k++)
      s += longint'($signed(rom_mem[k+1])) * longint'($signed(cur_x[k]));
    q = s >>> 8;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    qa = q[15:0];
    exp_q.push_back({15'd0, (q > 0), qa});
  endtask

  task automatic load_spec_rom();
    for (int a = 0; a < 256; a++) rom_mem[a] = 16'h0000;
    rom_mem[3] = 16'h0300;
    rom_mem[4] = 16'h0400;
    rom_mem[5] = 16'h0500;
    rom_mem[6] = 16'h0600;
  endtask

  task automatic set_x_all(input logic [15:0] v);
    for (int k = 0; k < N; k++) cur_x[k] = v;
  endtask

  // Feed one activation, waiting (bounded) for the MAC-state transfer.
  task automatic feed_term(input int k, inout bit addr_ok);
    bit fired;
    int guard = 0;
    x_valid = 1'b1;
    x_data  = cur_x[k];
    fired   = 1'b0;
    while (!fired && guard < 100) begin
      fired = x_ready;
      if (fired && rom_addr !== 16'(k + 1)) addr_ok = 1'b0;
      step();
      guard++;
    end
    if (!fired) check("x_timeout", 0, 1);
    x_valid = 1'b0;
  endtask

  task automatic run_eval(input int stall_max, input bit stall_fixed, input int yr_delay,
                          input bit poke_start, input bit chk_lat);
    bit          addr_ok = 1'b1;
    bit          held_ok = 1'b1;
    int          guard = 0;
    int          d;
    logic [31:0] exp;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    for (int k = 0; k < N; k++) begin
      d = stall_fixed ? 3 : int'($urandom_range(0, stall_max));
      x_valid = 1'b0;
      for (int s = 0; s < d; s++) begin
        if (poke_start && k == 5) start = 1'b1;
        if (x_ready && rom_addr !== 16'(k + 1)) addr_ok = 1'b0;
        step();
        start = 1'b0;
      end
      feed_term(k, addr_ok);
    end
    while (!y_valid && guard < 100) begin
      step();
      guard++;
    end
    check("y_valid_seen", y_valid, 1);
    if (chk_lat) check("latency", cyc, 2 * N + 1);
    exp = exp_q.pop_front();
    check("y_acc", y_acc, exp[15:0]);
    check("y_fire", y_fire, exp[16]);
    for (int s = 0; s < yr_delay; s++) begin
      step();
      if (y_valid !== 1'b1 || y_acc !== exp[15:0] || y_fire !== exp[16]) held_ok = 1'b0;
    end
    if (yr_delay > 0) check("out_hold", held_ok, 1);
    y_ready = 1'b1;
    if (poke_start) start = 1'b1;
    step();
    y_ready = 1'b0;
    start   = 1'b0;
    check("busy_after", busy, 0);
    check("y_valid_after", y_valid, 0);
    check("addr_stable", addr_ok, 1);
    if (poke_start) begin
      repeat (N * 3) step();
      check("no_second_busy", busy, 0);
      check("no_second_valid", y_valid, 0);
    end
  endtask

  task automatic abort_at_idx4();
    bit addr_ok = 1'b1;
    int guard = 0;
    bit seen_valid = 1'b0;
    set_x_all(16'h0100);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) feed_term(k, addr_ok);
    while (!x_ready && guard < 20) begin
      step();
      guard++;
    end
    check("abort_idx4_addr", rom_addr, 16'd5);
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_y_valid", y_valid, 0);
    check("abort_rom_addr", rom_addr, 0);
    check("abort_x_ready", x_ready, 0);
    check("abort_y_acc", y_acc, 0);
    x_valid = 1'b1;
    repeat (30) begin
      step();
      if (y_valid) seen_valid = 1'b1;
    end
    x_valid = 1'b0;
    check("abort_no_result", seen_valid, 0);
    check("abort_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x_valid = 1'b0; y_ready = 1'b0; x_data = 16'h0000;
    load_spec_rom();
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_x_ready", x_ready, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_acc", y_acc, 0);
    check("rst_y_fire", y_fire, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    step();

    set_x_all(16'h0100);
    exp_q.push_back({15'd0, 1'b1, 16'h1200});
    run_eval(0, 1'b0, 0, 1'b0, 1'b1);

    set_x_all(16'hFF00);
    exp_q.push_back({15'd0, 1'b0, 16'hEE00});
    run_eval(0, 1'b0, 0, 1'b0, 1'b1);

    set_x_all(16'h7FFF);
    exp_q.push_back({15'd0, 1'b1, 16'h7FFF});
    run_eval(0, 1'b0, 1, 1'b0, 1'b0);

    set_x_all(16'h0100);
    exp_q.push_back({15'd0, 1'b1, 16'h1200});
    run_eval(0, 1'b1, 5, 1'b0, 1'b0);

    abort_at_idx4();
    set_x_all(16'h0100);
    exp_q.push_back({15'd0, 1'b1, 16'h1200});
    run_eval(0, 1'b0, 0, 1'b0, 1'b1);

    set_x_all(16'h0100);
    exp_q.push_back({15'd0, 1'b1, 16'h1200});
    run_eval(0, 1'b1, 2, 1'b1, 1'b0);

    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < N; k++) begin
        rom_mem[k+1] = (it % 3 == 0) ? 16'($urandom_range(0, 65535))
                                     : 16'($signed(16'($urandom_range(0, 2047))) - 16'sd1024);
        cur_x[k] = (it % 4 == 1) ? 16'($urandom_range(0, 65535))
                                 : 16'($signed(16'($urandom_range(0, 1023))) - 16'sd512);
      end
      model_push();
      run_eval(4, 1'b0, int'($urandom_range(0, 4)), 1'b0, 1'b0);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
